// File: rtl/wbmem.sv
// In-order Wishbone memory responder with programmable wait cycles.
// Define WBMEM_PIPELINE_EN for a DEPTH-entry queue; default is one outstanding request.
module wbmem #(
   parameter int ARCHBITSZ = 32,
   parameter int SIZE      = 1024,
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 1,
   parameter     INITFILE  = "",
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
   localparam int SELBITSZ  = ARCHBITSZ/8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [ADDRBITSZ-1:0] wb_addr_i,
   input  logic [SELBITSZ-1:0]  wb_sel_i,
   input  logic [ARCHBITSZ-1:0] wb_dat_i,
   output logic                 wb_bsy_o,
   output logic                 wb_ack_o,
   output logic [ARCHBITSZ-1:0] wb_dat_o
);

`ifdef WBMEM_PIPELINE_EN
   localparam int QD = DEPTH;
`else
   localparam int QD = 1;
`endif
   localparam int PW = (QD > 1) ? $clog2(QD) : 1;
   localparam int CW = $clog2(QD + 1);
   localparam int IW = $clog2(SIZE);
   localparam int EW = 1 + IW + SELBITSZ + ARCHBITSZ;

   typedef enum logic {IDLE, WAIT} state_t;

   logic [ARCHBITSZ-1:0] mem [SIZE];
   logic [EW-1:0]        q [2**PW];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_nx;
   state_t               state;
   logic [3:0]           cnt;
   logic [ARCHBITSZ-1:0] rd_q;
   logic                 push;
   logic                 pop;
   logic                 start;
   logic                 head_we;
   logic [IW-1:0]        head_idx;
   logic [SELBITSZ-1:0]  head_sel;
   logic [ARCHBITSZ-1:0] head_dat;
   logic                 addr_unused;

   assign addr_unused = ^wb_addr_i[ADDRBITSZ-1:IW];

   assign push  = wb_cyc_i & wb_stb_i & ~wb_bsy_o;
   assign start = (state == IDLE) && (count != '0);
   assign pop   = (state == WAIT) && (cnt == 4'd1);

   // The in-flight request stays at the head until it completes,
   // so the count covers every outstanding request.
   assign {head_we, head_idx, head_sel, head_dat} = q[rd_ptr];

   always_comb begin
      count_nx = count;
      if (push && !pop)
         count_nx = count + 1'b1;
      else if (pop && !push)
         count_nx = count - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push)
         q[wr_ptr] <= {wb_we_i, wb_addr_i[IW-1:0], wb_sel_i, wb_dat_i};
   end

   always_ff @(posedge clk_i) begin
      if (start)
         rd_q <= mem[head_idx];
      if (pop && head_we) begin
         for (int b = 0; b < SELBITSZ; b++) begin
            if (head_sel[b])
               mem[head_idx][8*b +: 8] <= head_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wb_bsy_o <= 1'b1;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         count    <= count_nx;
         wb_bsy_o <= (count_nx == CW'(QD));
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  cnt   <= 4'(LATENCY);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  wb_ack_o <= 1'b1;
                  if (!head_we)
                     wb_dat_o <= rd_q;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase
      end
   end

endmodule
